countdown_timer_p: RTL

Parametrised HH:MM:SS BCD timer for the clock project. It is a settable countdown with a selectable count-up (stopwatch) mode, an on-digit edit cursor, pause/resume and an expiry indication. It generates its own 1 s tick from `clk` and drives six BCD digits directly to the display mux.

---
 rtl/clk_timer_pkg.sv | 32 +++
 rtl/bcd_hms_step.sv | 50 +++++
 rtl/countdown_timer_p.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/clk_timer_pkg.sv
// rtl/clk_timer_pkg.sv - state, digit-limit and cursor constants shared by the HH:MM:SS timer
package clk_timer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_EDIT  = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_PAUSE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

    localparam logic [2:0] CUR_SEC1  = 3'd0;
    localparam logic [2:0] CUR_SEC10 = 3'd1;
    localparam logic [2:0] CUR_MIN1  = 3'd2;
    localparam logic [2:0] CUR_MIN10 = 3'd3;
    localparam logic [2:0] CUR_HR1   = 3'd4;
    localparam logic [2:0] CUR_HR10  = 3'd5;

    // Wrap limit of digit idx in the packed {hr_10,hr_1,min_10,min_1,sec_10,sec_1} value
    function automatic logic [3:0] digit_max(input logic [2:0] idx, input logic [3:0] hr10_max);
        case (idx)
            CUR_SEC10, CUR_MIN10: digit_max = DIGIT_MAX_5;
            CUR_HR10:             digit_max = hr10_max;
            CUR_SEC1, CUR_MIN1, CUR_HR1: digit_max = DIGIT_MAX_9;
            default:              digit_max = DIGIT_MAX_9;
        endcase
    endfunction

endpackage

// File: rtl/bcd_hms_step.sv
// rtl/bcd_hms_step.sv - combinational +/-1 on a packed HH:MM:SS BCD value with limit flag
module bcd_hms_step
    import clk_timer_pkg::*;
#(
    parameter int HR10_MAX = 9
) (
    input  logic [23:0] value,
    input  logic        dir_up,
    output logic [23:0] next,
    output logic        at_limit
);

    localparam logic [23:0] MAX_VALUE = {4'(HR10_MAX), 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};

    logic       carry;
    logic [3:0] dig;
    logic [3:0] dmax;

    // carry doubles as borrow; it ripples from sec_1 upward and stops at the first digit that does not wrap
    always_comb begin
        next  = value;
        carry = 1'b1;
        dig   = 4'd0;
        dmax  = 4'd0;
        for (int i = 0; i < 6; i++) begin
            dig  = value[i*4 +: 4];
            dmax = digit_max(3'(i), 4'(HR10_MAX));
            if (carry) begin
                if (dir_up) begin
                    if (dig >= dmax) begin
                        dig = 4'd0;
                    end else begin
                        dig   = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = dmax;
                    end else begin
                        dig   = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            next[i*4 +: 4] = dig;
        end
        at_limit = dir_up ? (next == MAX_VALUE) : (next == 24'd0);
    end

endmodule

// File: rtl/countdown_timer_p.sv
// rtl/countdown_timer_p.sv - HH:MM:SS BCD countdown/stopwatch with edit cursor; COUNTDOWN_AUTO_RELOAD_EN enables reload-on-expiry
module countdown_timer_p
    import clk_timer_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int HR10_MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_modify,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_clear,
    input  logic       mode_up,
    output logic [3:0] hr_10,
    output logic [3:0] hr_1,
    output logic [3:0] min_10,
    output logic [3:0] min_1,
    output logic [3:0] sec_10,
    output logic [3:0] sec_1,
    output logic [2:0] cursor,
    output logic [2:0] state,
    output logic       running,
    output logic       expired
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [6:0]    btns, btn_q, ev;
    logic [23:0]   value, value_n, preset, preset_n, step_value;
    logic [PW-1:0] presc, presc_n;
    logic [2:0]    cursor_n;
    state_t        state_n;
    logic          mode_q, mode_n, reload_q, reload_n, expired_n, step_limit, tick;
    logic          ev_start, ev_modify, ev_up, ev_down, ev_left, ev_right, ev_clear;
    logic [3:0]    cur_digit, cur_max, edit_digit;

    assign btns = {btn_clear, btn_right, btn_left, btn_down, btn_up, btn_modify, btn_start};
    assign ev   = btns & ~btn_q;
    assign {ev_clear, ev_right, ev_left, ev_down, ev_up, ev_modify, ev_start} = ev;

    assign {hr_10, hr_1, min_10, min_1, sec_10, sec_1} = value;

    assign tick       = (state == ST_RUN) && (presc == PRESC_LAST);
    assign cur_digit  = value[{cursor, 2'b00} +: 4];
    assign cur_max    = digit_max(cursor, 4'(HR10_MAX));
    assign edit_digit = ev_up ? ((cur_digit >= cur_max) ? 4'd0 : cur_digit + 4'd1)
                              : ((cur_digit == 4'd0) ? cur_max : cur_digit - 4'd1);

    bcd_hms_step #(.HR10_MAX(HR10_MAX)) u_step (
        .value    (value),
        .dir_up   (mode_q),
        .next     (step_value),
        .at_limit (step_limit)
    );

    always_comb begin
        state_n  = state;
        value_n  = value;
        preset_n = preset;
        cursor_n = cursor;
        presc_n  = presc;
        mode_n   = mode_q;
        reload_n = 1'b0;
        if (state == ST_RUN) begin
            presc_n = tick ? '0 : presc + PW'(1);
        end
        if (ev_clear) begin
            state_n  = ST_IDLE;
            value_n  = '0;
            preset_n = '0;
            presc_n  = '0;
            cursor_n = CUR_SEC1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ev_start && (mode_up || value != 24'd0)) begin
                        state_n = ST_RUN;
                        presc_n = '0;
                        mode_n  = mode_up;
                    end else if (ev_modify) begin
                        state_n  = ST_EDIT;
                        cursor_n = CUR_SEC1;
                    end
                end
                ST_EDIT: begin
                    if (ev_modify) begin
                        state_n  = ST_IDLE;
                        preset_n = value;
                    end else if (ev_up ^ ev_down) begin
                        value_n[{cursor, 2'b00} +: 4] = edit_digit;
                    end else if (ev_left) begin
                        cursor_n = (cursor == CUR_HR10) ? CUR_SEC1 : cursor + 3'd1;
                    end else if (ev_right) begin
                        cursor_n = (cursor == CUR_SEC1) ? CUR_HR10 : cursor - 3'd1;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        value_n = step_value;
                        if (step_limit) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (!mode_q) begin
                                value_n  = preset;
                                reload_n = 1'b1;
                            end else begin
                                state_n = ST_DONE;
                            end
`else
                            state_n = ST_DONE;
`endif
                        end
                    end
                    // a terminal tick wins over a simultaneous pause request
                    if (ev_start && state_n == ST_RUN) begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (ev_start) begin
                        state_n = ST_RUN;
                    end else if (ev_modify) begin
                        state_n = ST_EDIT;
                    end
                end
                ST_DONE: begin
                    if (ev_start || ev_modify) begin
                        state_n = ST_IDLE;
                        value_n = preset;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        expired_n = !ev_clear && (((state == ST_DONE) && (state_n == ST_DONE)) || reload_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q    <= '0;
            value    <= '0;
            preset   <= '0;
            presc    <= '0;
            cursor   <= CUR_SEC1;
            state    <= ST_IDLE;
            mode_q   <= 1'b0;
            reload_q <= 1'b0;
            running  <= 1'b0;
            expired  <= 1'b0;
        end else begin
            btn_q    <= btns;
            value    <= value_n;
            preset   <= preset_n;
            presc    <= presc_n;
            cursor   <= cursor_n;
            state    <= state_n;
            mode_q   <= mode_n;
            reload_q <= reload_n;
            running  <= (state_n == ST_RUN);
            expired  <= expired_n;
        end
    end

endmodule
